// File: rtl/demux14_stream.sv
// Registered 1-to-4 stream demultiplexer with a one-entry holding register per channel.
// Optional per-channel accept counters are built when DEMUX_STATS_EN is defined.
module demux14_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [4*CNT_W-1:0]   stats
);

    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       sel_onehot;
    logic [3:0]       load;
    logic             accept;

    // A full channel blocks only traffic addressed to it; it frees up when its consumer is ready.
    always_comb begin
        sel_onehot = 4'b0001 << in_sel;
        in_ready   = ~rst & (~valid_q[in_sel] | out_ready[in_sel]);
        accept     = in_valid & in_ready;
        load       = accept ? sel_onehot : 4'b0000;
        valid_d    = load | (valid_q & ~out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 4'b0000;
        end else begin
            valid_q <= valid_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_chan
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q[k] <= '0;
                end else if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end

            assign out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    endgenerate

    assign out_valid = valid_q;

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q [4];

    // Counters wrap freely; they count accepts, not drains.
    generate
        for (k = 0; k < 4; k++) begin : g_stats
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q[k] <= '0;
                end else if (load[k]) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end

            assign stats[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    endgenerate
`else
    assign stats = '0;
`endif

endmodule

// File: tb/tb_demux14_stream.sv
// Directed self-checking bench for demux14_stream; stats checks adapt to DEMUX_STATS_EN.
module tb_demux14_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_sel;
    logic [WIDTH-1:0]     in_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [4*WIDTH-1:0]   out_data;
    logic [4*CNT_W-1:0]   stats;

    int vecCount = 0;
    int errCount = 0;

    demux14_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stats     (stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        assert (obs === exp)
        else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] chan(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    // A stalled word must not change until it is accepted.
    logic             stalledPrev = 1'b0;
    logic [1:0]       selPrev;
    logic [WIDTH-1:0] dataPrev;
    always @(posedge clk) begin
        if (stalledPrev && !rst && in_valid) begin
            checkOutput("upstream_stable", {54'd0, in_sel, in_data}, {54'd0, selPrev, dataPrev});
        end
        stalledPrev = in_valid && !in_ready && !rst;
        selPrev     = in_sel;
        dataPrev    = in_data;
    end

    initial begin
        rst       = 1'b1;
        out_ready = 4'b0000;
        applyStimulus(1'b1, 2'd0, 8'h00);

        // Reset held for two edges
        tick();
        checkOutput("rst_in_ready_0", 64'(in_ready), 64'd0);
        tick();
        checkOutput("rst_in_ready_1", 64'(in_ready), 64'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00);
        checkOutput("rel_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rel_out_data", 64'(out_data), 64'd0);
        checkOutput("rel_stats", 64'(stats), 64'd0);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b0, 2'(s), 8'h00);
            checkOutput("rel_in_ready", 64'(in_ready), 64'd1);
        end

        // Basic routing with all consumers ready
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i), 8'(8'hA0 + i));
            checkOutput("route_in_ready", 64'(in_ready), 64'd1);
            tick();
            checkOutput("route_valid", 64'(out_valid), 64'(4'b0001 << i));
            checkOutput("route_data", 64'(chan(i)), 64'(8'hA0 + i));
        end
        applyStimulus(1'b0, 2'd0, 8'h00);
        tick();
        checkOutput("route_drained", 64'(out_valid), 64'd0);
        checkOutput("route_all_data", 64'(out_data), 64'hA3A2A1A0);

        // Per-channel backpressure
        out_ready = 4'b0000;
        applyStimulus(1'b1, 2'd2, 8'h55);
        checkOutput("bp_ready_55", 64'(in_ready), 64'd1);
        tick();
        checkOutput("bp_valid_55", 64'(out_valid), 64'b0100);
        checkOutput("bp_data_55", 64'(chan(2)), 64'h55);
        applyStimulus(1'b1, 2'd1, 8'h77);
        checkOutput("bp_ready_77", 64'(in_ready), 64'd1);
        tick();
        checkOutput("bp_valid_77", 64'(out_valid), 64'b0110);
        checkOutput("bp_data_77", 64'(chan(1)), 64'h77);
        applyStimulus(1'b1, 2'd2, 8'h66);
        checkOutput("bp_blocked_66", 64'(in_ready), 64'd0);
        tick();
        checkOutput("bp_held_valid", 64'(out_valid), 64'b0110);
        checkOutput("bp_held_data", 64'(chan(2)), 64'h55);
        out_ready = 4'b0100;
        #1;
        checkOutput("bp_unblock_66", 64'(in_ready), 64'd1);
        tick();
        checkOutput("bp_valid_66", 64'(out_valid), 64'b0110);
        checkOutput("bp_data_66", 64'(chan(2)), 64'h66);
        checkOutput("bp_ch1_kept", 64'(chan(1)), 64'h77);
        applyStimulus(1'b0, 2'd0, 8'h00);
        tick();
        checkOutput("bp_ch2_drain", 64'(out_valid), 64'b0010);
        checkOutput("bp_ch2_hold", 64'(chan(2)), 64'h66);

        // Streaming drain+load on channel 3
        out_ready = 4'b1000;
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b1, 2'd3, 8'(j));
            checkOutput("stream_ready", 64'(in_ready), 64'd1);
            tick();
            checkOutput("stream_valid", 64'(out_valid), 64'b1010);
            checkOutput("stream_data", 64'(chan(3)), 64'(j));
        end
        applyStimulus(1'b0, 2'd0, 8'h00);
        tick();
        checkOutput("stream_end_valid", 64'(out_valid), 64'b0010);
        checkOutput("stream_end_data", 64'(chan(3)), 64'h0F);

        // Reset while channels 0 and 1 are full
        out_ready = 4'b0000;
        applyStimulus(1'b1, 2'd0, 8'h11);
        tick();
        checkOutput("mid_valid", 64'(out_valid), 64'b0011);
        rst = 1'b1;
        applyStimulus(1'b1, 2'd2, 8'h99);
        checkOutput("mid_rst_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00);
        checkOutput("mid_valid_clr", 64'(out_valid), 64'd0);
        checkOutput("mid_data_clr", 64'(out_data), 64'd0);
        checkOutput("mid_stats_clr", 64'(stats), 64'd0);
        out_ready = 4'b1111;
        tick();
        checkOutput("mid_no_ghost", 64'(out_valid), 64'd0);

        // 257 accepts to channel 0
        out_ready = 4'b0001;
        for (int n = 0; n < 257; n++) begin
            applyStimulus(1'b1, 2'd0, 8'(n));
            tick();
        end
        applyStimulus(1'b0, 2'd0, 8'h00);
        checkOutput("wrap_last_data", 64'(chan(0)), 64'h00);
`ifdef DEMUX_STATS_EN
        checkOutput("stats_wrap", 64'(stats), 64'h00000001);
`else
        checkOutput("stats_zero", 64'(stats), 64'd0);
`endif
        tick();
        checkOutput("wrap_drained", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/demux14_stream.md
Name: demux14_stream

Overview:
- Registered 1-to-4 demultiplexer; the inverse of the team's 4:1 select-mux benchmark.
- Takes one input stream with a valid/ready handshake and a 2-bit select, and routes each accepted word to one of four output channels.
- Each channel has a one-entry holding register with its own valid/ready handshake.
- Used as the routing/fan-out stage feeding the four mux data inputs in the TOY datapath benchmarks.

Parameters:
- WIDTH, 8, data word width in bits (minimum 1).
- CNT_W, 8, width of each per-channel accept counter (used only with DEMUX_STATS_EN).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the word this cycle.
- in_sel  in  2  destination channel, 0..3 (s1 = in_sel[1], s0 = in_sel[0]).
- in_data  in  WIDTH  input word.
- out_valid  out  4  per-channel word-present flags; bit k = channel k.
- out_ready  in  4  per-channel downstream ready.
- out_data  out  4*WIDTH  flattened channel registers; channel k occupies [k*WIDTH +: WIDTH].
- stats  out  4*CNT_W  flattened per-channel accept counters; channel k occupies [k*CNT_W +: CNT_W].

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid <= 4'b0000, all out_data <= 0, all stats <= 0.
  - in_ready is forced to 0 combinationally whenever rst=1.
  - Reset mid-transfer discards any held words without delivery.
- in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]).
  - Combinational from registered state, downstream ready and in_sel.
  - A full channel therefore blocks only traffic addressed to it.
- accept = in_valid & in_ready. On accept:
  - Channel in_sel data register <= in_data.
  - out_valid[in_sel] <= 1.
- Latency: a word accepted at edge N is visible on out_data/out_valid from edge N (1 cycle after it was presented).
- Drain: for each channel k, if out_valid[k] & out_ready[k] and no accept to k in the same cycle, then out_valid[k] <= 0. The data register holds its old value.
- Same channel drains and loads in one cycle: new word loaded, out_valid[k] stays 1, no bubble. Full throughput is 1 word/cycle per channel.
- Different channels drain and load in one cycle: the events are independent. At most one load per cycle (single input).
- Channel data registers change only on accept to that channel or on reset.
- Upstream rule: while in_valid=1 & in_ready=0, in_data and in_sel must stay stable until accept. The bench flags any violation as an error.
- out_ready is ignored for channels with out_valid=0.
- No internal state machine beyond the four per-channel EMPTY/FULL bits.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain+load or on no drain.

Optional Feature:
- Macro DEMUX_STATS_EN.
- Defined:
  - Each channel has a CNT_W-bit counter, incremented by 1 on every accept to that channel.
  - Counters wrap from 2^CNT_W-1 to 0, have no saturation, and reset to 0.
  - stats reflects the registered counter values.
- Undefined:
  - No counter flops are built.
  - stats is tied to all zeros.
  - Routing behaviour is identical.

Test Plan:
- Reset release: rst=1 for 2 cycles, then 0.
  - During reset: in_ready=0.
  - After release: out_valid=0000, out_data all 0, stats=0, in_ready=1 for any in_sel.
- Basic routing, out_ready=1111: send 0xA0,0xA1,0xA2,0xA3 with in_sel=0,1,2,3 on consecutive cycles.
  - Each word appears 1 cycle later on its channel only.
  - out_valid pulses 0001, 0010, 0100, 1000.
- Per-channel backpressure: out_ready=0000.
  - Send 0x55 to ch2 -> accepted; out_valid=0100.
  - Second word 0x66 to ch2 -> in_ready=0, held. Meanwhile 0x77 to ch1 -> accepted.
  - Set out_ready[2]=1 -> 0x66 accepted that cycle; ch2 shows 0x66, out_valid[2] stays 1.
- Streaming drain+load: out_ready[3]=1, 16 back-to-back words 0x00..0x0F to ch3.
  - in_ready stays 1 throughout; ch3 outputs 0x00..0x0F in order with no bubbles.
- Reset mid-operation: channels 0 and 1 full (out_ready=0), assert rst for 1 cycle.
  - out_valid=0000, data 0; held words never observed.
- With DEMUX_STATS_EN, CNT_W=8: 257 accepts to ch0 -> stats ch0 = 1 (wrap), other channels 0.
  - Without the macro: stats=0 always.
